// File: rtl/vl_strip_ctrl.sv
// vsetvl / strip-mining controller: decodes SEW/LMUL/AVL into vl/vtype and,
// in strip mode, hands out one strip of at most VLMAX elements per handshake.
module vl_strip_ctrl #(
  parameter int VLEN     = 128,
  parameter int ELEN     = 64,
  parameter int MAX_LMUL = 4,
  parameter int AVL_W    = 9,
  localparam int VL_W    = $clog2(VLEN * (1 << MAX_LMUL) / 8) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_sew,
  input  logic [2:0]       req_lmul,
  input  logic [AVL_W-1:0] req_avl,
  input  logic             req_strip,
  input  logic             abort,
  output logic             strip_valid,
  input  logic             strip_ready,
  output logic [VL_W-1:0]  strip_vl,
  output logic [AVL_W-1:0] strip_idx,
  output logic             strip_last,
  output logic             done,
  output logic             aborted,
  output logic [VL_W-1:0]  csr_vl,
  output logic [5:0]       csr_vtype,
  output logic             vill
);

  localparam int CMP_W = (AVL_W > VL_W) ? AVL_W : VL_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_STRIP = 2'd2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_sew;
  logic [2:0]       r_lmul;
  logic [AVL_W-1:0] r_avl;
  logic             r_strip;
  logic [AVL_W-1:0] r_rem;
  logic [VL_W-1:0]  r_vlmax;
  logic             r_req_ready;
  logic             r_strip_valid;
  logic [VL_W-1:0]  r_strip_vl;
  logic [AVL_W-1:0] r_strip_idx;
  logic             r_strip_last;
  logic             r_done;
  logic             r_aborted;
  logic [VL_W-1:0]  r_csr_vl;
  logic [5:0]       r_csr_vtype;
  logic             r_vill;

  logic [31:0]      w_esz;
  logic [31:0]      w_vlmax_full;
  logic             w_legal;
  logic [VL_W-1:0]  w_vlmax;
  logic [VL_W-1:0]  w_vl;
  logic             w_first_last;
  logic [CMP_W-1:0] w_avl_c;
  logic [CMP_W-1:0] w_vlmax_c;
  logic [AVL_W-1:0] w_nrem;
  logic [CMP_W-1:0] w_nrem_c;
  logic [CMP_W-1:0] w_rvmax_c;
  logic [VL_W-1:0]  w_nvl;
  logic             w_nlast;

  // Legality/VLMAX of the latched request, and the next strip after a handshake.
  always_comb begin
    w_esz        = 32'd8 << r_sew;
    w_legal      = (r_sew <= 3'd4) && (w_esz <= 32'(ELEN)) && (w_esz <= 32'(VLEN)) &&
                   ({29'd0, r_lmul} <= 32'(MAX_LMUL));
    w_vlmax_full = (32'(VLEN) >> (32'd3 + {29'd0, r_sew})) << r_lmul;
    w_vlmax      = w_vlmax_full[VL_W-1:0];
    w_avl_c      = CMP_W'(r_avl);
    w_vlmax_c    = CMP_W'(w_vlmax);
    w_vl         = (w_avl_c < w_vlmax_c) ? VL_W'(w_avl_c) : w_vlmax;
    w_first_last = (w_avl_c <= w_vlmax_c);
    w_nrem       = r_rem - AVL_W'(r_strip_vl);
    w_nrem_c     = CMP_W'(w_nrem);
    w_rvmax_c    = CMP_W'(r_vlmax);
    w_nvl        = (w_nrem_c < w_rvmax_c) ? VL_W'(w_nrem_c) : r_vlmax;
    w_nlast      = (w_nrem_c <= w_rvmax_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_sew         <= 3'd0;
      r_lmul        <= 3'd0;
      r_avl         <= '0;
      r_strip       <= 1'b0;
      r_rem         <= '0;
      r_vlmax       <= '0;
      r_req_ready   <= 1'b1;
      r_strip_valid <= 1'b0;
      r_strip_vl    <= '0;
      r_strip_idx   <= '0;
      r_strip_last  <= 1'b0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
      r_csr_vl      <= '0;
      r_csr_vtype   <= 6'd0;
      r_vill        <= 1'b1;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_sew       <= req_sew;
            r_lmul      <= req_lmul;
            r_avl       <= req_avl;
            r_strip     <= req_strip;
            r_req_ready <= 1'b0;
            r_state     <= S_CALC;
          end
        end
        S_CALC: begin
          r_csr_vtype <= {r_lmul, r_sew};
          if (!w_legal) begin
            r_vill      <= 1'b1;
            r_csr_vl    <= '0;
            r_done      <= 1'b1;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_vill   <= 1'b0;
            r_csr_vl <= w_vl;
            r_vlmax  <= w_vlmax;
            if (!r_strip || (r_avl == '0)) begin
              r_done      <= 1'b1;
              r_req_ready <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_rem         <= r_avl;
              r_strip_idx   <= '0;
              r_strip_vl    <= w_vl;
              r_strip_last  <= w_first_last;
              r_strip_valid <= 1'b1;
              r_state       <= S_STRIP;
            end
          end
        end
        S_STRIP: begin
          // Abort beats a same-cycle handshake: the offered strip is dropped uncounted.
          if (abort) begin
            r_strip_valid <= 1'b0;
            r_done        <= 1'b1;
            r_aborted     <= 1'b1;
            r_req_ready   <= 1'b1;
            r_state       <= S_IDLE;
          end else if (strip_ready) begin
            r_rem       <= w_nrem;
            r_strip_idx <= r_strip_idx + 1'b1;
            if (r_strip_last) begin
              r_strip_valid <= 1'b0;
              r_done        <= 1'b1;
              r_req_ready   <= 1'b1;
              r_state       <= S_IDLE;
            end else begin
              r_strip_vl   <= w_nvl;
              r_strip_last <= w_nlast;
            end
          end
        end
        default: begin
          r_strip_valid <= 1'b0;
          r_req_ready   <= 1'b1;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign strip_valid = r_strip_valid;
  assign strip_vl    = r_strip_vl;
  assign strip_idx   = r_strip_idx;
  assign strip_last  = r_strip_last;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign csr_vl      = r_csr_vl;
  assign csr_vtype   = r_csr_vtype;
  assign vill        = r_vill;

endmodule
